// File: rtl/serial_sum_collect.sv
// serial_sum_collect
//   Collects the LSB-first sum bits of a serial adder into a parallel word.
//   When the final bit arrives, the adder's carry is appended on top.
//   The result is held with a valid/ready handshake until it is consumed.
//
// Parameters
//   WIDTH      sum bits per frame (2..16)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      opens a new frame (restarts a frame in progress)
//   bit_valid  qualifies sum_bit / carry_bit this cycle
//   sum_bit    serial sum bit, LSB first
//   carry_bit  adder carry, sampled on the last bit of a frame only
//   out_ready  downstream accepts out
//   out        {final carry, sum[WIDTH-1:0]}
//   out_valid  out holds a complete result (HOLD state)
//   busy       frame being collected (SHIFT state)
//   abort      one-cycle pulse after a partial frame was discarded by start
//   out_parity XOR of all out bits, present only with SERIAL_SUM_PARITY_EN
//
// Optional feature macro: SERIAL_SUM_PARITY_EN
module serial_sum_collect #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           bit_valid,
  input  logic           sum_bit,
  input  logic           carry_bit,
  input  logic           out_ready,
  output logic [WIDTH:0] out,
  output logic           out_valid,
  output logic           busy,
  output logic           abort
`ifdef SERIAL_SUM_PARITY_EN
  ,
  output logic           out_parity
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx, base_cnt;
  logic [WIDTH-1:0] sreg, sreg_nx, base_sreg;
  logic [WIDTH:0]   result;
  logic             load;
  logic             abort_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    sreg_nx   = sreg;
    base_cnt  = cnt;
    base_sreg = sreg;
    load      = 1'b0;
    abort_nx  = 1'b0;
    // Assembled word if the current bit is the last one of the frame.
    result    = {carry_bit, sum_bit, sreg[WIDTH-1:1]};
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
          sreg_nx  = '0;
        end
      end
      SHIFT: begin
        // A restart discards the partial frame; a bit arriving in the same
        // cycle becomes bit 0 of the new frame.
        if (start) begin
          base_cnt  = '0;
          base_sreg = '0;
          abort_nx  = 1'b1;
        end
        cnt_nx  = base_cnt;
        sreg_nx = base_sreg;
        result  = {carry_bit, sum_bit, base_sreg[WIDTH-1:1]};
        if (bit_valid) begin
          if (base_cnt == LAST) begin
            load     = 1'b1;
            state_nx = HOLD;
            cnt_nx   = '0;
            sreg_nx  = '0;
          end else begin
            cnt_nx  = base_cnt + CW'(1);
            sreg_nx = {sum_bit, base_sreg[WIDTH-1:1]};
          end
        end
      end
      HOLD: begin
        // start without out_ready is ignored so the held result survives.
        if (out_ready) begin
          state_nx = start ? SHIFT : IDLE;
          cnt_nx   = '0;
          sreg_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        sreg_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      sreg  <= '0;
      out   <= '0;
      abort <= 1'b0;
    end else begin
      cnt   <= cnt_nx;
      sreg  <= sreg_nx;
      abort <= abort_nx;
      if (load) out <= result;
    end
  end

`ifdef SERIAL_SUM_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       out_parity <= 1'b0;
    else if (load) out_parity <= ^result;
  end
`endif

  assign busy      = (state == SHIFT);
  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_serial_sum_collect.sv
// Bench for serial_sum_collect: directed frames, a frame-level reference
// model checked every cycle, plus literal expectations at key points.
module tb_serial_sum_collect;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start, bit_valid, sum_bit, carry_bit, out_ready;
  logic [W:0]   out;
  logic         out_valid, busy, abort;
`ifdef SERIAL_SUM_PARITY_EN
  logic         out_parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_sum_collect #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .sum_bit   (sum_bit),
    .carry_bit (carry_bit),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .abort     (abort)
`ifdef SERIAL_SUM_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame-level reference: accumulates the numeric value of the frame.
  typedef struct {
    bit collect;
    bit hold;
    int cnt;
    int acc;
    int outv;
    bit abort;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t mnext(mstate_t c, bit s, bit bv, bit sb, bit cb, bit rdy);
    mstate_t nx;
    nx = c;
    nx.abort = 1'b0;
    if (c.hold) begin
      if (rdy) begin
        nx.hold = 1'b0;
        if (s) begin
          nx.collect = 1'b1;
          nx.cnt = 0;
          nx.acc = 0;
        end
      end
    end else if (c.collect) begin
      if (s) begin
        nx.abort = 1'b1;
        nx.cnt = 0;
        nx.acc = 0;
      end
      if (bv) begin
        nx.acc = nx.acc + (int'(sb) << nx.cnt);
        nx.cnt = nx.cnt + 1;
        if (nx.cnt == W) begin
          nx.outv = nx.acc + (int'(cb) << W);
          nx.hold = 1'b1;
          nx.collect = 1'b0;
        end
      end
    end else if (s) begin
      nx.collect = 1'b1;
      nx.cnt = 0;
      nx.acc = 0;
    end
    return nx;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{default: 0};
    else     m <= mnext(m, start, bit_valid, sum_bit, carry_bit, out_ready);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_out", int'(out), m.outv);
    chk("model_out_valid", int'(out_valid), int'(m.hold));
    chk("model_busy", int'(busy), int'(m.collect));
    chk("model_abort", int'(abort), int'(m.abort));
`ifdef SERIAL_SUM_PARITY_EN
    chk("model_parity", int'(out_parity), int'(^m.outv));
`endif
  end

  task automatic cyc(input bit s, input bit bv, input bit sb, input bit cb, input bit rdy);
    start     = s;
    bit_valid = bv;
    sum_bit   = sb;
    carry_bit = cb;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 0; bit_valid = 0; sum_bit = 0; carry_bit = 0; out_ready = 0;
    @(posedge clk);
    #1;
    chk("reset_out", int'(out), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_abort", int'(abort), 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);

    // 9+12: sum bits 1,0,1,0 (LSB first), carry 1 -> 21
    cyc(1, 0, 0, 0, 1);
    chk("t1_busy", int'(busy), 1);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 0, 1, 1);
    chk("t1_out", int'(out), 21);
    chk("t1_out_valid", int'(out_valid), 1);
`ifdef SERIAL_SUM_PARITY_EN
    chk("t1_parity", int'(out_parity), 1);
`endif
    cyc(0, 0, 0, 0, 1);
    chk("t1_valid_drop", int'(out_valid), 0);
    chk("t1_out_kept", int'(out), 21);

    // Same frame, held for 5 cycles without ready; start in HOLD ignored.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", int'(out_valid), 1);
      chk("t2_hold_out", int'(out), 21);
      cyc((i == 1), 1, 1, 1, 0);
    end
    chk("t2_hold_valid5", int'(out_valid), 1);
    chk("t2_hold_out5", int'(out), 21);
    cyc(0, 0, 0, 0, 1);
    chk("t2_idle_valid", int'(out_valid), 0);
    chk("t2_idle_busy", int'(busy), 0);

    // 6+7=13: bits 1,0,1,1 (LSB first) with 2-cycle bubbles, carry 0
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 1);
    for (int b = 1; b < 4; b++) begin
      cyc(0, 0, 1, 1, 1);
      chk("t3_bubble_busy", int'(busy), 1);
      cyc(0, 0, 0, 1, 1);
      chk("t3_bubble_busy", int'(busy), 1);
      cyc(0, 1, (b != 1), 0, 1);
    end
    chk("t3_out", int'(out), 13);
    chk("t3_out_valid", int'(out_valid), 1);
    cyc(0, 0, 0, 0, 1);

    // Restart after 2 bits; restart cycle carries bit 0 of the new frame.
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(1, 1, 1, 0, 1);
    chk("t4_abort", int'(abort), 1);
    chk("t4_busy", int'(busy), 1);
    cyc(0, 1, 1, 0, 1);
    chk("t4_abort_clear", int'(abort), 0);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 1, 1);
    chk("t4_out", int'(out), 31);
    chk("t4_out_valid", int'(out_valid), 1);
    cyc(0, 0, 0, 0, 1);

    // Asynchronous reset after 3 bits.
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_out", int'(out), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_abort", int'(abort), 0);
    start = 0; bit_valid = 1; sum_bit = 1; carry_bit = 1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 1, 1);
      chk("t5_no_valid", int'(out_valid), 0);
      chk("t5_idle_busy", int'(busy), 0);
    end

    // Back-to-back: 10 (bits 0,1,0,1, carry 0), then start in handshake.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("t6_out_a", int'(out), 10);
    cyc(1, 1, 1, 1, 1);
    chk("t6_b2b_busy", int'(busy), 1);
    chk("t6_b2b_valid", int'(out_valid), 0);
    // 19: bits 1,1,0,0, carry 1
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    chk("t6_out_b", int'(out), 19);
    chk("t6_out_b_valid", int'(out_valid), 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
